// File: rtl/mtrx_pkg.sv
// Shared types and constants for the transform matrix generator.
// Packing order: element 11 in the MSBs, element 44 in the LSBs.
package mtrx_pkg;

  typedef enum logic [1:0] {
    M_IDENTITY,
    M_TRANSLATE,
    M_SCALE,
    M_SCALE_TRANSLATE
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_X,
    S_MUL_Y,
    S_MUL_Z,
    S_OUT
  } state_e;

  localparam int E11 = 15;
  localparam int E14 = 12;
  localparam int E22 = 10;
  localparam int E24 = 8;
  localparam int E33 = 5;
  localparam int E34 = 4;
  localparam int E44 = 0;

  function automatic int one(input int frac_w);
    return 1 << frac_w;
  endfunction

endpackage

// File: rtl/transform_matrix_gen_fx_mul.sv
// Signed fixed-point multiply with floor shift by FRAC_W.
// TRANSFORM_MTRX_SATURATE_EN selects clamping instead of wrapping.
module fx_mul
  #(parameter int DATA_W = 16,
    parameter int FRAC_W = 5)
  (input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] p_o);

  logic signed [2*DATA_W-1:0] full;

  assign full = $signed(a_i) * $signed(b_i);

`ifdef TRANSFORM_MTRX_SATURATE_EN
  logic signed [2*DATA_W-1:0] sh;
  logic ovf_pos;
  logic ovf_neg;

  assign sh = full >>> FRAC_W;
  // Upper bits must all equal the sign bit to fit DATA_W.
  assign ovf_pos = !sh[2*DATA_W-1] &&
                   (|sh[2*DATA_W-2:DATA_W-1]);
  assign ovf_neg = sh[2*DATA_W-1] &&
                   !(&sh[2*DATA_W-2:DATA_W-1]);

  always_comb begin
    p_o = sh[DATA_W-1:0];
    if (ovf_pos)
      p_o = {1'b0, {(DATA_W-1){1'b1}}};
    else if (ovf_neg)
      p_o = {1'b1, {(DATA_W-1){1'b0}}};
  end
`else
  assign p_o = DATA_W'(full >>> FRAC_W);
`endif

endmodule

// File: rtl/transform_matrix_gen.sv
// 4x4 fixed-point homogeneous transform generator with one shared
// multiplier. Build option: TRANSFORM_MTRX_SATURATE_EN.
module transform_matrix_gen
  import mtrx_pkg::*;
  #(parameter int DATA_W = 16,
    parameter int FRAC_W = 5)
  (input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             mode,
   input  logic [DATA_W-1:0]      xc,
   input  logic [DATA_W-1:0]      yc,
   input  logic [DATA_W-1:0]      zc,
   input  logic [DATA_W-1:0]      sx,
   input  logic [DATA_W-1:0]      sy,
   input  logic [DATA_W-1:0]      sz,
   output logic                   mtrx_valid,
   input  logic                   mtrx_ready,
   output logic [16*DATA_W-1:0]   mtrx,
   output logic                   busy);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(one(FRAC_W));

  state_e state_q;
  mode_e  mode_q;
  logic   req_ready_q;
  logic   mtrx_valid_q;
  logic   busy_q;

  logic [DATA_W-1:0] xc_q, yc_q, zc_q;
  logic [DATA_W-1:0] sx_q, sy_q, sz_q;

  logic [15:0][DATA_W-1:0] mtrx_q;
  logic [15:0][DATA_W-1:0] init_d;

  logic [DATA_W-1:0] mul_a, mul_b, mul_p;

  mode_e mode_in;
  assign mode_in = mode_e'(mode);

  always_comb begin
    init_d      = '0;
    init_d[E11] = mode[1] ? sx : ONE;
    init_d[E22] = mode[1] ? sy : ONE;
    init_d[E33] = mode[1] ? sz : ONE;
    init_d[E44] = ONE;
    if (mode_in == M_TRANSLATE) begin
      init_d[E14] = xc;
      init_d[E24] = yc;
      init_d[E34] = zc;
    end
  end

  // One multiplier shared across the three MUL states.
  always_comb begin
    mul_a = sx_q;
    mul_b = xc_q;
    unique case (state_q)
      S_MUL_Y: begin
        mul_a = sy_q;
        mul_b = yc_q;
      end
      S_MUL_Z: begin
        mul_a = sz_q;
        mul_b = zc_q;
      end
      default: ;
    endcase
  end

  fx_mul #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_fx_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_IDENTITY;
      req_ready_q  <= 1'b1;
      mtrx_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      xc_q         <= '0;
      yc_q         <= '0;
      zc_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      sz_q         <= '0;
      mtrx_q       <= '0;
      mtrx_q[E11]  <= ONE;
      mtrx_q[E22]  <= ONE;
      mtrx_q[E33]  <= ONE;
      mtrx_q[E44]  <= ONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mode_q      <= mode_in;
            xc_q        <= xc;
            yc_q        <= yc;
            zc_q        <= zc;
            sx_q        <= sx;
            sy_q        <= sy;
            sz_q        <= sz;
            mtrx_q      <= init_d;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (mode_in == M_SCALE_TRANSLATE) begin
              state_q <= S_MUL_X;
            end else begin
              state_q      <= S_OUT;
              mtrx_valid_q <= 1'b1;
            end
          end
        end
        S_MUL_X: begin
          if (mode_q == M_SCALE_TRANSLATE)
            mtrx_q[E14] <= mul_p;
          state_q <= S_MUL_Y;
        end
        S_MUL_Y: begin
          if (mode_q == M_SCALE_TRANSLATE)
            mtrx_q[E24] <= mul_p;
          state_q <= S_MUL_Z;
        end
        S_MUL_Z: begin
          if (mode_q == M_SCALE_TRANSLATE)
            mtrx_q[E34] <= mul_p;
          state_q      <= S_OUT;
          mtrx_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (mtrx_ready) begin
            state_q      <= S_IDLE;
            mtrx_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          mtrx_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mtrx_valid = mtrx_valid_q;
  assign busy       = busy_q;
  assign mtrx       = mtrx_q;

endmodule

// File: tb/tb_transform_matrix_gen.sv
// Directed bench for transform_matrix_gen with an expected-matrix
// scoreboard filled on request and drained on consumption.
module tb_transform_matrix_gen;

  localparam int W  = 16;
  localparam int F  = 5;
  localparam int MW = 16 * W;
  localparam logic [W-1:0] ONE = 16'h0020;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  xc = '0, yc = '0, zc = '0;
  logic [W-1:0]  sx = '0, sy = '0, sz = '0;
  logic          mtrx_valid;
  logic          mtrx_ready = 1'b0;
  logic [MW-1:0] mtrx;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] ident;
  logic [MW-1:0] snap;

  transform_matrix_gen #(.DATA_W(W), .FRAC_W(F)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mode       (mode),
    .xc         (xc),
    .yc         (yc),
    .zc         (zc),
    .sx         (sx),
    .sy         (sy),
    .sz         (sz),
    .mtrx_valid (mtrx_valid),
    .mtrx_ready (mtrx_ready),
    .mtrx       (mtrx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [MW-1:0] obs,
                     input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fxm(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> F;
`ifdef TRANSFORM_MTRX_SATURATE_EN
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
`endif
    return W'(p);
  endfunction

  function automatic logic [MW-1:0] model(
      input logic [1:0] m,
      input logic [W-1:0] x, y, z, a, b, c);
    logic [15:0][W-1:0] r;
    r     = '0;
    r[15] = m[1] ? a : ONE;
    r[10] = m[1] ? b : ONE;
    r[5]  = m[1] ? c : ONE;
    r[0]  = ONE;
    if (m == 2'd1) begin
      r[12] = x; r[8] = y; r[4] = z;
    end else if (m == 2'd3) begin
      r[12] = fxm(a, x);
      r[8]  = fxm(b, y);
      r[4]  = fxm(c, z);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] elem(input logic [MW-1:0] v,
                                        input int idx);
    return v[idx*W +: W];
  endfunction

  task automatic drive(input logic [1:0] m,
                       input logic [W-1:0] x, y, z, a, b, c);
    mode = m; xc = x; yc = y; zc = z;
    sx = a; sy = b; sz = c;
  endtask

  // Issue a request, push its expected matrix, wait for mtrx_valid.
  task automatic request(input string tag, input logic [1:0] m,
                         input logic [W-1:0] x, y, z, a, b, c,
                         input int exp_lat);
    int lat;
    drive(m, x, y, z, a, b, c);
    req_valid = 1'b1;
    chk({tag, "_ready_pre"}, MW'(req_ready), MW'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(model(m, x, y, z, a, b, c));
    drive($urandom_range(3), W'($urandom), W'($urandom), W'($urandom),
          W'($urandom), W'($urandom), W'($urandom));
    lat = 1;
    while (!mtrx_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, MW'(lat), MW'(exp_lat));
  endtask

  task automatic consume(input string tag);
    logic [MW-1:0] e;
    chk({tag, "_sb_nonempty"}, MW'(exp_q.size() != 0), MW'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_mtrx"}, mtrx, e);
    end
    mtrx_ready = 1'b1;
    @(posedge clk); #1;
    mtrx_ready = 1'b0;
    chk({tag, "_idle_ready"}, MW'(req_ready), MW'(1));
    chk({tag, "_idle_valid"}, MW'(mtrx_valid), MW'(0));
    chk({tag, "_idle_busy"}, MW'(busy), MW'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, MW'(mtrx_valid), MW'(0));
    chk({tag, "_ready"}, MW'(req_ready), MW'(1));
    chk({tag, "_busy"}, MW'(busy), MW'(0));
    chk({tag, "_mtrx"}, mtrx, ident);
  endtask

  initial begin
    logic [W-1:0] ovf_exp;
    logic seen;

    ident = model(2'd0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");

    request("tr", 2'd1, 16'h0005, 16'hFFFD, 16'h0100,
            16'h1111, 16'h2222, 16'h3333, 1);
    chk("tr_e14", MW'(elem(mtrx, 12)), MW'(16'h0005));
    chk("tr_e24", MW'(elem(mtrx, 8)), MW'(16'hFFFD));
    chk("tr_e34", MW'(elem(mtrx, 4)), MW'(16'h0100));
    chk("tr_e11", MW'(elem(mtrx, 15)), MW'(16'h0020));
    consume("tr");

    request("id", 2'd0, 16'h1234, 16'h5678, 16'h9ABC,
            16'h0040, 16'h0040, 16'h0040, 1);
    consume("id");

    request("sc", 2'd2, 16'h0007, 16'h0008, 16'h0009,
            16'h0003, 16'hFFF0, 16'h7FFF, 1);
    consume("sc");

    request("st", 2'd3, 16'h0030, 16'h0020, 16'h0021,
            16'h0040, 16'hFFE0, 16'h0010, 4);
    chk("st_e11", MW'(elem(mtrx, 15)), MW'(16'h0040));
    chk("st_e22", MW'(elem(mtrx, 10)), MW'(16'hFFE0));
    chk("st_e33", MW'(elem(mtrx, 5)), MW'(16'h0010));
    chk("st_e14", MW'(elem(mtrx, 12)), MW'(16'h0060));
    chk("st_e24", MW'(elem(mtrx, 8)), MW'(16'hFFE0));
    chk("st_e34", MW'(elem(mtrx, 4)), MW'(16'h0010));
    chk("st_busy", MW'(busy), MW'(1));
    consume("st");

    request("bp", 2'd1, 16'h0A0A, 16'h0B0B, 16'h0C0C,
            16'h0001, 16'h0002, 16'h0003, 1);
    snap = mtrx;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      drive(2'(i), W'($urandom), W'($urandom), W'($urandom),
            W'($urandom), W'($urandom), W'($urandom));
      @(posedge clk); #1;
      chk("bp_valid", MW'(mtrx_valid), MW'(1));
      chk("bp_stable", mtrx, snap);
      chk("bp_ready", MW'(req_ready), MW'(0));
    end
    req_valid = 1'b0;
    consume("bp");

`ifdef TRANSFORM_MTRX_SATURATE_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'hF800;
`endif
    request("ovf", 2'd3, 16'h7FFF, 16'h0001, 16'h0001,
            16'h7FFF, 16'h0020, 16'h0020, 4);
    chk("ovf_e14", MW'(elem(mtrx, 12)), MW'(ovf_exp));
    consume("ovf");

    request("rout", 2'd1, 16'h0011, 16'h0022, 16'h0033,
            16'h0000, 16'h0000, 16'h0000, 1);
    rst = 1'b1;
    #1;
    chk_reset("rst_out");
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;

    drive(2'd3, 16'h0100, 16'h0200, 16'h0300,
          16'h0040, 16'h0040, 16'h0040);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(model(mode, xc, yc, zc, sx, sy, sz));
    @(posedge clk); #1;
    chk("rmul_busy", MW'(busy), MW'(1));
    rst = 1'b1;
    #1;
    chk_reset("rst_mul");
    exp_q.delete();
    #2 rst = 1'b0;
    mtrx_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mtrx_valid) seen = 1'b1;
    end
    mtrx_ready = 1'b0;
    chk("rmul_no_valid", MW'(seen), MW'(0));
    request("post", 2'd0, 16'h0001, 16'h0002, 16'h0003,
            16'h0004, 16'h0005, 16'h0006, 1);
    consume("post");

    for (int i = 0; i < 6; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(3));
      request("rnd", m, W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), W'($urandom), W'($urandom),
              (m == 2'd3) ? 4 : 1);
      consume("rnd");
    end

    chk("sb_empty", MW'(exp_q.size()), MW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transform_matrix_gen.md
# transform_matrix_gen

Sequential generator for 4x4 fixed-point homogeneous transform matrices (identity, translate, scale, scale-composed translate) feeding the vertex-transform pipeline. It accepts a request on a valid/ready handshake, computes any needed products with one shared fixed-point multiplier over successive cycles, and holds the packed 16-element matrix on a valid/ready output until it is consumed. It generalises the fixed 16-bit translate-only matrix builder with parametrised width and fraction, and adds mode selection, multiplication and flow control.

## Interface
- DATA_W, 16, element width in bits (signed two's complement)
- FRAC_W, 5, fractional bits; 1.0 = 1 << FRAC_W (0x0020 at defaults)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- mode  in  2  0 IDENTITY, 1 TRANSLATE, 2 SCALE, 3 SCALE_TRANSLATE
- xc, yc, zc  in  DATA_W each  signed translation
- sx, sy, sz  in  DATA_W each  signed scale factors
- mtrx_valid  out  1  mtrx holds a finished matrix
- mtrx_ready  in  1  consumer accepts mtrx
- mtrx  out  16*DATA_W  row-major packed matrix, element 11 in MSBs, element 44 in LSBs
- busy  out  1  high in any state except IDLE

## Operation
- Request is accepted on a rising edge with req_valid && req_ready. mode, xc..zc and sx..sz are captured into registers; later input changes are ignored until the next acceptance.
- All off-diagonal elements are 0 except column 4 of rows 1-3. Element 44 is always ONE.
- IDENTITY: diag ONE, column 4 zero.
- TRANSLATE: diag ONE, column 4 = xc, yc, zc.
- SCALE: diag sx, sy, sz; column 4 zero.
- SCALE_TRANSLATE (S*T): diag sx, sy, sz; column 4 = sx*xc, sy*yc, sz*zc in fixed point.
- Fixed-point multiply: full 2*DATA_W signed product, arithmetic shift right by FRAC_W (floor). The low DATA_W bits are the result; overflow wraps unless configured otherwise.
- FSM states:
  - IDLE: req_ready=1. On accept, go to MUL_X if mode 3, otherwise to OUT with the matrix written.
  - MUL_X, MUL_Y, MUL_Z: one product per cycle, written into the corresponding element. MUL_Z goes to OUT.
  - OUT: mtrx_valid=1. On mtrx_ready, go to IDLE.
- req_ready is 0 outside IDLE. There is no overlap of request and output phases.
- mtrx is stable whenever mtrx_valid=1. After consumption it keeps its last value.
- Reset, including mid-MUL or mid-OUT: state returns to IDLE, the pending result is discarded, and no mtrx_valid is produced for the aborted request.

## Timing
- Reset values: req_ready=1, mtrx_valid=0, busy=0, mtrx=identity (diag ONE, rest 0), internal captured operands 0.
- Modes 0-2: mtrx_valid rises on the edge after acceptance (latency 1).
- Mode 3: mtrx_valid rises 4 edges after acceptance.
- Minimum request-to-request spacing:
  - 2 cycles for modes 0-2 with mtrx_ready held high.
  - 5 cycles for mode 3 with mtrx_ready held high.
- mtrx_ready is ignored outside OUT.

## Configuration
- TRANSFORM_MTRX_SATURATE_EN
  - Defined: products outside the signed DATA_W range clamp to max positive or min negative.
  - Undefined: products wrap (low DATA_W bits of the shifted product).
  - Affects mode 3 column-4 elements only.

## Structure
- Package mtrx_pkg holds:
  - the mode enum (IDENTITY, TRANSLATE, SCALE, SCALE_TRANSLATE)
  - the FSM state enum
  - the ONE constant function of FRAC_W
  - the element index constants for the packing order
- One sub-module, fx_mul: DATA_W/FRAC_W parametrised signed multiply, shift and optional saturation (honours TRANSFORM_MTRX_SATURATE_EN). It is combinational and instantiated once; the FSM time-multiplexes it across x, y, z.

## Test plan
- Reset: assert rst mid-run -> mtrx_valid=0, req_ready=1, busy=0, mtrx diag 0x0020 and all other elements 0.
- TRANSLATE, xc=0x0005, yc=0xFFFD, zc=0x0100 -> mtrx_valid 1 cycle after accept; elements 14/24/34 = 0x0005/0xFFFD/0x0100; diag 0x0020.
- SCALE_TRANSLATE, sx=0x0040, xc=0x0030, sy=0xFFE0, yc=0x0020, sz=0x0010, zc=0x0021 -> valid 4 cycles after accept; diag 0x0040/0xFFE0/0x0010; column 4 = 0x0060/0xFFE0/0x0010 (floor).
- Backpressure: mtrx_ready low 5 cycles in OUT, inputs toggled -> mtrx_valid held, mtrx bit-stable, req_ready=0; consumed on first mtrx_ready, then IDLE next cycle.
- Overflow: mode 3, sx=xc=0x7FFF -> element 14 = 0xF800 without macro, 0x7FFF with TRANSFORM_MTRX_SATURATE_EN.
- Reset in MUL_Y -> no mtrx_valid afterwards; a following IDENTITY request completes normally with latency 1.
